// File: rtl/msk_rnd_pkg.sv
// Shared definitions for the masked-randomness feeder: LFSR geometry, defaults,
// the HPC2 randomness count and the feeder FSM states.
package msk_rnd_pkg;

    localparam int LFSR_L     = 80;
    // Bit indices of x^80 + x^79 + x^43 + x^42 + 1 in a left-shifting register.
    localparam int TAP_A      = 79;
    localparam int TAP_B      = 78;
    localparam int TAP_C      = 42;
    localparam int TAP_D      = 41;
    localparam int SEED_W_DEF = 16;
    localparam int WARMUP_DEF = 64;

    function automatic int hpc2_rnd_count(input int d);
        return d * (d - 1) / 2;
    endfunction

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_SEEDING  = 2'd1,
        ST_WARMUP   = 2'd2,
        ST_RUN      = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/msk_lfsr_stepw.sv
// Combinational W-step unrolled Fibonacci LFSR next-state. New bits enter at
// bit 0, so the low W bits of the result are the W most recently generated bits.
module msk_lfsr_stepw
    import msk_rnd_pkg::*;
#(
    parameter int L = LFSR_L,
    parameter int W = 1
) (
    input  logic [L-1:0] state_in,
    output logic [L-1:0] state_out
);

    logic [L-1:0] s;

    always_comb begin
        // NOTE: blocking assignments here are deliberate; each loop iteration
        // must see the value produced by the previous one.
        s = state_in;
        for (int i = 0; i < W; i++) begin
            s = {s[L-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
        end
        state_out = s;
    end

endmodule

// File: rtl/msk_rnd_feeder.sv
// Fresh-randomness producer for masked gadgets: word-serial seeding, a warmup
// phase that discards output, then one W-bit word per valid/ready handshake.
module msk_rnd_feeder
    import msk_rnd_pkg::*;
#(
    parameter int d      = 2,
    parameter int W      = hpc2_rnd_count(d),
    parameter int L      = LFSR_L,
    parameter int SEED_W = SEED_W_DEF,
    parameter int WARMUP = WARMUP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEED_W-1:0] seed_in,
    input  logic              seed_valid,
    output logic              seed_ready,
    input  logic              reseed,
    output logic [W-1:0]      rnd_out,
    output logic              rnd_valid,
    input  logic              rnd_ready
);

    localparam int            N_WORDS   = L / SEED_W;
    localparam int            CNT_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);
    localparam logic [7:0]    WARM_LAST = 8'(WARMUP - 1);

    feeder_state_e    fsm_q, fsm_d;
    logic [L-1:0]     lfsr_q, lfsr_d;
    logic [L-1:0]     lfsr_step;
    logic [L-1:0]     seed_load;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [7:0]       warm_cnt_q, warm_cnt_d;
    logic             seed_fire;

    msk_lfsr_stepw #(
        .L (L),
        .W (W)
    ) u_step (
        .state_in  (lfsr_q),
        .state_out (lfsr_step)
    );

    assign seed_ready = (fsm_q == ST_UNSEEDED) || (fsm_q == ST_SEEDING);
    assign rnd_valid  = (fsm_q == ST_RUN);
    assign rnd_out    = lfsr_q[W-1:0];
    assign seed_fire  = seed_valid && seed_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        fsm_d      = fsm_q;
        lfsr_d     = lfsr_q;
        word_cnt_d = word_cnt_q;
        warm_cnt_d = warm_cnt_q;
        seed_load  = {lfsr_q[L-SEED_W-1:0], seed_in};

        if (reseed && (fsm_q != ST_UNSEEDED)) begin
            // Reload restarts from the first seed word; any concurrent seed
            // word is dropped and the LFSR contents will be overwritten.
            fsm_d      = ST_SEEDING;
            word_cnt_d = '0;
        end else begin
            case (fsm_q)
                ST_UNSEEDED, ST_SEEDING: begin
                    if (seed_fire) begin
                        if (word_cnt_q == LAST_WORD) begin
                            // The all-zero state is the LFSR lock-up point.
                            if (seed_load == '0) begin
                                seed_load[0] = 1'b1;
                            end
                            fsm_d      = ST_WARMUP;
                            word_cnt_d = '0;
                            warm_cnt_d = '0;
                        end else begin
                            fsm_d      = ST_SEEDING;
                            word_cnt_d = word_cnt_q + CNT_W'(1);
                        end
                        lfsr_d = seed_load;
                    end
                end
                ST_WARMUP: begin
                    lfsr_d     = lfsr_step;
                    warm_cnt_d = warm_cnt_q + 8'd1;
                    if (warm_cnt_q == WARM_LAST) begin
                        fsm_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rnd_ready) begin
                        lfsr_d = lfsr_step;
                    end
                end
                default: fsm_d = ST_UNSEEDED;
            endcase
        end
    end

    // NOTE: asynchronous reset clears every register, including the LFSR, so
    // no randomness survives a reset; state updates use non-blocking assigns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= ST_UNSEEDED;
            lfsr_q     <= '0;
            word_cnt_q <= '0;
            warm_cnt_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            lfsr_q     <= lfsr_d;
            word_cnt_q <= word_cnt_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

endmodule

// File: tb/tb_msk_rnd_feeder.sv
// Self-checking bench for msk_rnd_feeder: directed phases with random seeds,
// checked against a bit-stream recurrence model of the LFSR sequence.
module tb_msk_rnd_feeder;

    logic        clk;
    logic        rst_n;
    logic [15:0] seed_in;
    logic        seed_valid;
    logic        reseed;
    logic        rnd_ready;

    logic        seed_ready;
    logic [0:0]  rnd_out;
    logic        rnd_valid;

    logic        sr3, sr4, sr8;
    logic [2:0]  rnd3;
    logic [5:0]  rnd6;
    logic [27:0] rnd28;
    logic        rv3, rv4, rv8;

    int n_asserts = 0;
    int n_fail    = 0;

    // Generated bit stream: x[0..79] is the seed, MSB of the first word first;
    // x[n] = x[n-80] ^ x[n-79] ^ x[n-43] ^ x[n-42] thereafter.
    bit seq[$];

    msk_rnd_feeder #(.d(2), .WARMUP(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_valid(seed_valid),
        .seed_ready(seed_ready), .reseed(reseed), .rnd_out(rnd_out),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready)
    );

    msk_rnd_feeder #(.d(3), .WARMUP(1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_valid(seed_valid),
        .seed_ready(sr3), .reseed(reseed), .rnd_out(rnd3),
        .rnd_valid(rv3), .rnd_ready(1'b1)
    );

    msk_rnd_feeder #(.d(4), .WARMUP(1)) u_d4 (
        .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_valid(seed_valid),
        .seed_ready(sr4), .reseed(reseed), .rnd_out(rnd6),
        .rnd_valid(rv4), .rnd_ready(1'b1)
    );

    msk_rnd_feeder #(.d(8), .WARMUP(1)) u_d8 (
        .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_valid(seed_valid),
        .seed_ready(sr8), .reseed(reseed), .rnd_out(rnd28),
        .rnd_valid(rv8), .rnd_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_seed(input logic [79:0] s);
        seq.delete();
        for (int k = 0; k < 80; k++) seq.push_back(s[79-k]);
        if (s == '0) seq[79] = 1'b1;
    endtask

    // Word n of a feeder with width w and warmup length warm.
    task automatic model_word(input int w, input int warm, input int n, output logic [79:0] v);
        int t;
        int m;
        t = 79 + w * (warm + n);
        while (seq.size() <= t) begin
            m = seq.size();
            seq.push_back(seq[m-80] ^ seq[m-79] ^ seq[m-43] ^ seq[m-42]);
        end
        v = '0;
        for (int j = 0; j < w; j++) v[j] = seq[t-j];
    endtask

    task automatic send_seed(input logic [15:0] w);
        seed_in    = w;
        seed_valid = 1'b1;
        check("seed_ready_before_accept", 80'(seed_ready), 80'(1));
        tick();
        seed_valid = 1'b0;
    endtask

    task automatic load_seed(input logic [79:0] s);
        for (int i = 0; i < 5; i++) send_seed(s[79-16*i -: 16]);
    endtask

    task automatic wait_valid(input string tag);
        int lat;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!rnd_valid && lat < 300);
        check(tag, 80'(lat), 80'(64));
    endtask

    task automatic check_words(input string tag, input int first, input int count);
        logic [79:0] exp;
        rnd_ready = 1'b1;
        for (int n = first; n < first + count; n++) begin
            model_word(1, 64, n, exp);
            check({tag, "_valid"}, 80'(rnd_valid), 80'(1));
            check(tag, 80'(rnd_out), exp);
            tick();
        end
    endtask

    task automatic pulse_reseed();
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rnd_valid", 80'(rnd_valid), 80'(0));
        check("rst_rnd_out", 80'(rnd_out), 80'(0));
        check("rst_seed_ready", 80'(seed_ready), 80'(1));
        check("rst_lfsr", u_dut.lfsr_q, 80'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [79:0] s;
        logic [79:0] exp;
        int          ones;

        rst_n      = 1'b0;
        seed_in    = '0;
        seed_valid = 1'b0;
        reseed     = 1'b0;
        rnd_ready  = 1'b0;
        tick();
        tick();
        check("por_rnd_valid", 80'(rnd_valid), 80'(0));
        check("por_rnd_out", 80'(rnd_out), 80'(0));
        check("por_seed_ready", 80'(seed_ready), 80'(1));
        rst_n = 1'b1;
        tick();

        // Reseed while unseeded is ignored; the block stays ready for a seed.
        pulse_reseed();
        check("unseeded_reseed_ready", 80'(seed_ready), 80'(1));
        check("unseeded_reseed_cnt", 80'(u_dut.word_cnt_q), 80'(0));

        // Seeding latency and golden sequence.
        s = 80'h1234_5678_9ABC_DEF0_0F0F;
        model_seed(s);
        load_seed(s);
        check("warmup_no_valid", 80'(rnd_valid), 80'(0));
        check("warmup_no_seed_ready", 80'(seed_ready), 80'(0));
        wait_valid("latency_golden");
        check_words("golden", 0, 200);

        // Backpressure: word 200 is on the bus and must hold.
        rnd_ready = 1'b0;
        model_word(1, 64, 200, exp);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", 80'(rnd_valid), 80'(1));
            check("hold_word", 80'(rnd_out), exp);
            tick();
        end
        check_words("resume", 200, 20);

        // Reset in the middle of RUN.
        do_reset();

        // All-zero seed is forced to ...0001 and never locks up.
        model_seed(80'h0);
        load_seed(80'h0);
        check("zero_seed_state", u_dut.lfsr_q, 80'h1);
        wait_valid("latency_zero");
        rnd_ready = 1'b1;
        ones = 0;
        for (int n = 0; n < 10000; n++) begin
            model_word(1, 64, n, exp);
            check("zero_nonzero_state", 80'(u_dut.lfsr_q == '0), 80'(0));
            check("zero_word", 80'(rnd_out), exp);
            ones += int'(rnd_out);
            tick();
        end
        check("zero_not_constant", 80'(ones > 0 && ones < 10000), 80'(1));

        // Reseed in RUN, partial load, reseed again, full load.
        pulse_reseed();
        check("reseed_valid", 80'(rnd_valid), 80'(0));
        check("reseed_ready", 80'(seed_ready), 80'(1));
        check("reseed_cnt", 80'(u_dut.word_cnt_q), 80'(0));
        for (int i = 0; i < 3; i++) send_seed(16'($urandom()));
        pulse_reseed();
        check("reseed2_cnt", 80'(u_dut.word_cnt_q), 80'(0));
        s = 80'({$urandom(), $urandom(), $urandom()});
        model_seed(s);
        load_seed(s);
        wait_valid("latency_reseed");
        check_words("reseed_word", 0, 50);

        // Reseed colliding with a seed handshake drops the word.
        pulse_reseed();
        for (int i = 0; i < 2; i++) send_seed(16'($urandom()));
        seed_in    = 16'($urandom());
        seed_valid = 1'b1;
        reseed     = 1'b1;
        tick();
        seed_valid = 1'b0;
        reseed     = 1'b0;
        check("collide_ready", 80'(seed_ready), 80'(1));
        check("collide_cnt", 80'(u_dut.word_cnt_q), 80'(0));
        check("collide_valid", 80'(rnd_valid), 80'(0));
        s = 80'({$urandom(), $urandom(), $urandom()});
        model_seed(s);
        load_seed(s);
        wait_valid("latency_collide");
        check_words("collide_word", 0, 30);

        // seed_valid in RUN is ignored.
        rnd_ready = 1'b0;
        seed_valid = 1'b1;
        model_word(1, 64, 30, exp);
        for (int i = 0; i < 5; i++) begin
            seed_in = 16'($urandom());
            check("run_seed_ready", 80'(seed_ready), 80'(0));
            tick();
            check("run_seed_word", 80'(rnd_out), exp);
        end
        seed_valid = 1'b0;
        check_words("run_seed_after", 30, 10);

        // Parameter sweep, WARMUP = 1, continuous ready.
        do_reset();
        s = 80'({$urandom(), $urandom(), $urandom()});
        model_seed(s);
        load_seed(s);
        for (int n = 0; n < 40; n++) begin
            tick();
            check("d3_valid", 80'(rv3), 80'(1));
            check("d4_valid", 80'(rv4), 80'(1));
            check("d8_valid", 80'(rv8), 80'(1));
            model_word(3, 1, n, exp);
            check("d3_word", 80'(rnd3), exp);
            model_word(6, 1, n, exp);
            check("d4_word", 80'(rnd6), exp);
            model_word(28, 1, n, exp);
            check("d8_word", 80'(rnd28), exp);
        end
        check("sweep_seed_ready", 80'({sr3, sr4, sr8}), 80'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/msk_rnd_feeder.md
Name: msk_rnd_feeder

Overview:
- Fresh-randomness source for masked gadgets; the producer end of the `rnd` bus that HPC2-style AND gadgets consume.
- Expands a loaded seed into a W-bit random word per step using an unrolled maximal-length LFSR.
- Valid/ready handshake toward the gadget datapath; word-serial seed interface toward the key/seed controller.
- Sits between the top-level seed port and the gadget randomness buses of a masked core.

Parameters:
- d, 2, number of shares of the consuming gadget.
- W, d*(d-1)/2, random bits per word (the HPC2 randomness count); legal 1..L.
- L, 80, LFSR length; feedback polynomial x^80+x^79+x^43+x^42+1.
- SEED_W, 16, seed word width; L must be a multiple of SEED_W.
- WARMUP, 64, discarded W-bit steps after seeding; legal 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seed_in  in  SEED_W  seed word.
- seed_valid  in  1  seed word present.
- seed_ready  out  1  feeder accepts a seed word.
- reseed  in  1  single-cycle request to discard state and reload the seed.
- rnd_out  out  W  random word, driven directly from the state register.
- rnd_valid  out  1  rnd_out is fresh and unconsumed.
- rnd_ready  in  1  consumer takes rnd_out this cycle.

Behaviour:
- States: UNSEEDED, SEEDING, WARMUP, RUN; state encoding is registered.
- Reset (async assert, sync release) puts the block in UNSEEDED with: state register = 0, word counter = 0, warmup counter = 0, rnd_valid = 0, rnd_out = 0, seed_ready = 1.
- seed_ready = 1 in UNSEEDED and SEEDING only.
- Seed word accept (seed_valid & seed_ready):
  - state <= {state[L-SEED_W-1:0], seed_in}; first word ends up in the MSBs.
  - Word counter increments.
  - A word accepted in UNSEEDED moves the FSM to SEEDING.
- Seed completion: on the edge accepting word L/SEED_W:
  - If the resulting state is all-zero, force bit 0 to 1. The LFSR must never hold 0.
  - Go to WARMUP; clear the warmup counter.
- WARMUP:
  - Each cycle, state advances W LFSR steps (one unrolled next-state).
  - After exactly WARMUP cycles, go to RUN.
  - rnd_valid rises on the same edge, so the first valid word appears WARMUP cycles after the last seed word is accepted.
- RUN:
  - rnd_valid = 1, rnd_out = state[W-1:0].
  - On rnd_valid & rnd_ready, state advances W steps. The next cycle shows a new word: no bubble, full throughput of one word per clock.
  - rnd_ready = 0 holds state and rnd_out unchanged. A held word has not been consumed, so holding it is not reuse.
  - Every accepted word is used once only; the state never advances without a handshake in RUN.
- reseed (any state except UNSEEDED):
  - Next edge: state <= SEEDING, word counter = 0, rnd_valid = 0, seed_ready = 1.
  - LFSR contents are kept but are fully overwritten by the L/SEED_W new words.
  - reseed during SEEDING restarts the count; already-shifted words are overwritten.
  - reseed during WARMUP aborts the warmup.
- Simultaneous events:
  - reseed together with a seed word handshake: reseed wins and the word is dropped; seed_ready stays high.
  - reseed in UNSEEDED is ignored.
  - reseed together with an rnd handshake: the word counts as consumed, but the state does not advance (it is reloaded anyway).
- seed_valid outside UNSEEDED/SEEDING is ignored; no error flag.
- Reset mid-operation: immediate return to the reset values above, and all randomness is discarded.

Decomposition:
- Package msk_rnd_pkg holds:
  - localparams for L, the tap positions, SEED_W and the default WARMUP;
  - function hpc2_rnd_count(d) = d*(d-1)/2;
  - FSM state enum.
- Sub-module msk_lfsr_stepw: combinational W-step unrolled Fibonacci LFSR next-state (input L bits, output L bits).
  - Used by both WARMUP and RUN.
  - Reusable by other random sources in the codebase.

Test Plan:
1. Reset and seeding latency: assert rst_n = 0 mid-RUN -> rnd_valid = 0, rnd_out = 0 and seed_ready = 1 immediately. Then feed words 0x1234, 0x5678, 0x9ABC, 0xDEF0, 0x0F0F (d=2, W=1) -> rnd_valid rises exactly 64 cycles after the 5th accept, and the first 200 words match the golden C model bit-exact.
2. All-zero seed: five 0x0000 words -> internal state = 0x...0001 after load. Over 10000 handshakes the state is never 0 and the output is not constant.
3. Backpressure: in RUN, rnd_ready = 0 for 10 cycles -> rnd_out stable. Resume with rnd_ready = 1 -> sequence continues with no skipped or repeated word vs model.
4. Reseed in RUN: pulse reseed -> next cycle rnd_valid = 0, seed_ready = 1. Send 3 words, pulse reseed again, send 5 words -> output matches the model seeded with only the last 5 words.
5. Collision: reseed asserted in the same cycle as a seed handshake -> word dropped, counter = 0. Likewise seed_valid in RUN -> no state change.
6. Parameter sweep: d = 3 (W = 3), d = 4 (W = 6), d = 8 (W = 28), WARMUP = 1 -> output matches the model, one word per clock under continuous rnd_ready = 1.
